// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen
//   Per-channel edge-triggered pulse generator. A qualifying edge on trig[c]
//   captures in[c] onto out[c] for len+1 cycles. busy[c] is high for that
//   time. With RETRIG=1 an edge during a pulse restarts it. With RETRIG=0
//   that edge is dropped and the sticky miss[c] bit is set.
//
//   Optional build macro: EDGE_PULSE_GEN_SYNC_EN. When it is defined, a
//   two-flop synchroniser is placed on each trig bit before edge detection.
//
// Ports
//   clk       sole clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   trig      [CH]      per-channel trigger level
//   mode      [2*CH]    per-channel edge select: 00 fall, 01 rise, 10 both, 11 off
//   len       [LEN_W]   shared pulse length, pulse lasts len+1 cycles
//   in        [CH*N]    per-channel data, slice [N*c +: N]
//   out       [CH*N]    per-channel pulse data, zero while idle
//   busy      [CH]      channel pulse active
//   miss      [CH]      sticky: a qualifying edge was discarded
//   miss_clr            synchronous clear of all miss bits
//
// Channel FSM
//   state  | meaning
//   IDLE   | no pulse, out slice is zero
//   ACTIVE | pulse running, counter counts down to terminal count 0

module edge_pulse_gen #(
    parameter int N      = 8,
    parameter int CH     = 2,
    parameter int LEN_W  = 4,
    parameter bit RETRIG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH-1:0]     trig,
    input  logic [2*CH-1:0]   mode,
    input  logic [LEN_W-1:0]  len,
    input  logic [CH*N-1:0]   in,
    output logic [CH*N-1:0]   out,
    output logic [CH-1:0]     busy,
    output logic [CH-1:0]     miss,
    input  logic              miss_clr
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Edge detection stays blocked until the detector input is valid and prev
    // holds a real sample. Without this, a trig held high through reset would
    // look like a rising edge.
`ifdef EDGE_PULSE_GEN_SYNC_EN
    localparam logic [1:0] ARM_CYC = 2'd3;

    logic [CH-1:0] sync_1;
    logic [CH-1:0] sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= trig;
            sync_2 <= sync_1;
        end
    end

    logic [CH-1:0] det_src;
    assign det_src = sync_2;
`else
    localparam logic [1:0] ARM_CYC = 2'd1;

    logic [CH-1:0] det_src;
    assign det_src = trig;
`endif

    logic [1:0] arm_cnt;
    logic       armed;

    assign armed = (arm_cnt == ARM_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= 2'd0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    logic [CH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= det_src;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t           state, state_n;
        logic [LEN_W-1:0] cnt, cnt_n;
        logic [N-1:0]     out_q, out_n;
        logic             miss_q;
        logic             miss_set;
        logic             rise, fall, edge_det;
        logic [1:0]       m;

        assign m    = mode[2*c +: 2];
        assign rise =  det_src[c] & ~prev[c];
        assign fall = ~det_src[c] &  prev[c];

        always_comb begin
            edge_det = 1'b0;
            case (m)
                2'b00:   edge_det = fall;
                2'b01:   edge_det = rise;
                2'b10:   edge_det = rise | fall;
                default: edge_det = 1'b0;
            endcase
            edge_det = edge_det & armed;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
                out_q <= '0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                out_q <= out_n;
            end
        end

        // An edge that arrives on the terminal-count cycle takes the ACTIVE
        // path, so with RETRIG=1 the pulse extends without a gap cycle.
        always_comb begin
            state_n  = state;
            cnt_n    = cnt;
            out_n    = out_q;
            miss_set = 1'b0;
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state_n = ACTIVE;
                        cnt_n   = len;
                        out_n   = in[N*c +: N];
                    end
                end
                ACTIVE: begin
                    if (edge_det) begin
                        if (RETRIG) begin
                            cnt_n = len;
                            out_n = in[N*c +: N];
                        end else begin
                            miss_set = 1'b1;
                            if (cnt == '0) begin
                                state_n = IDLE;
                                out_n   = '0;
                            end else begin
                                cnt_n = cnt - 1'b1;
                            end
                        end
                    end else if (cnt == '0) begin
                        state_n = IDLE;
                        out_n   = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    out_n   = '0;
                end
            endcase
        end

        // A miss raised in the same cycle as miss_clr takes priority.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                miss_q <= 1'b0;
            end else if (miss_set) begin
                miss_q <= 1'b1;
            end else if (miss_clr) begin
                miss_q <= 1'b0;
            end
        end

        assign out[N*c +: N] = out_q;
        assign busy[c]       = (state == ACTIVE);
        assign miss[c]       = miss_q;
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen. It runs a RETRIG=1 instance and a
// RETRIG=0 instance side by side on the same stimulus.
module tb_edge_pulse_gen;

`ifdef EDGE_PULSE_GEN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  trig;
    logic [3:0]  mode;
    logic [3:0]  len;
    logic [15:0] in;
    logic        miss_clr;
    logic [15:0] out_a, out_b;
    logic [1:0]  busy_a, busy_b, miss_a, miss_b;

    int checks   = 0;
    int failures = 0;

    edge_pulse_gen #(.N(8), .CH(2), .LEN_W(4), .RETRIG(1'b1)) u_dut_rt (
        .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode), .len(len),
        .in(in), .out(out_a), .busy(busy_a), .miss(miss_a), .miss_clr(miss_clr)
    );

    edge_pulse_gen #(.N(8), .CH(2), .LEN_W(4), .RETRIG(1'b0)) u_dut_nr (
        .clk(clk), .rst_n(rst_n), .trig(trig), .mode(mode), .len(len),
        .in(in), .out(out_b), .busy(busy_b), .miss(miss_b), .miss_clr(miss_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rel;
    int nbusy;

    initial begin
        rst_n    = 1'b0;
        trig     = 2'b00;
        mode     = 4'b1111;
        len      = 4'd0;
        in       = 16'h0000;
        miss_clr = 1'b0;
        #12;
        chk("reset_out",  32'(out_a),  32'h0);
        chk("reset_busy", 32'(busy_a), 32'h0);
        chk("reset_miss", 32'(miss_a), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (LAT + 3) tick();

        // falling edge on ch0, len=0: single-cycle pulse of 0xA5
        mode = 4'b1100;
        trig[0] = 1'b1;
        repeat (LAT + 3) tick();
        chk("fall_rise_ignored", 32'(busy_a), 32'h0);
        in[7:0] = 8'hA5;
        len     = 4'd0;
        trig[0] = 1'b0;
        repeat (LAT) tick();
        chk("len0_pre", 32'(out_a[7:0]), 32'h0);
        tick();
        chk("len0_out",  32'(out_a[7:0]), 32'hA5);
        chk("len0_busy", 32'(busy_a[0]),  32'h1);
        tick();
        chk("len0_end_out",  32'(out_a[7:0]), 32'h0);
        chk("len0_end_busy", 32'(busy_a[0]),  32'h0);
        repeat (LAT + 2) tick();

        // both-edge mode on ch1, len=3: two separate 4-cycle pulses
        mode     = 4'b1011;
        in[15:8] = 8'h3C;
        len      = 4'd3;
        trig[1]  = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            rel = i - LAT;
            if ((rel >= 1 && rel <= 4) || (rel >= 7 && rel <= 10)) begin
                chk("both_out",  32'(out_a[15:8]), 32'h3C);
                chk("both_busy", 32'(busy_a[1]),   32'h1);
            end else begin
                chk("both_out",  32'(out_a[15:8]), 32'h0);
                chk("both_busy", 32'(busy_a[1]),   32'h0);
            end
            if (i == 6) trig[1] = 1'b0;
        end
        repeat (LAT + 2) tick();

        // retrigger on ch0, len=5. RETRIG=1 extends; RETRIG=0 flags a miss
        mode    = 4'b1101;
        len     = 4'd5;
        in[7:0] = 8'h11;
        trig[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            rel = i - LAT;
            if (rel >= 1 && rel <= 3)      chk("rt_out", 32'(out_a[7:0]), 32'h11);
            else if (rel >= 4 && rel <= 9) chk("rt_out", 32'(out_a[7:0]), 32'h22);
            else                           chk("rt_out", 32'(out_a[7:0]), 32'h0);
            if (rel >= 1 && rel <= 6) chk("nr_out", 32'(out_b[7:0]), 32'h11);
            else                      chk("nr_out", 32'(out_b[7:0]), 32'h0);
            chk("nr_miss", 32'(miss_b[0]), (rel >= 4) ? 32'h1 : 32'h0);
            chk("rt_miss", 32'(miss_a[0]), 32'h0);
            if (i == 1) trig[0] = 1'b0;
            if (i == 3) begin
                trig[0] = 1'b1;
                in[7:0] = 8'h22;
            end
        end
        miss_clr = 1'b1;
        tick();
        miss_clr = 1'b0;
        chk("miss_clr", 32'(miss_b), 32'h0);

        // max length on ch1; changing len mid-pulse must not alter duration
        mode    = 4'b0111;
        len     = 4'd15;
        trig[1] = 1'b0;
        repeat (LAT + 2) tick();
        trig[1] = 1'b1;
        nbusy   = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (busy_a[1]) nbusy++;
            if (i == 2) len = 4'd0;
        end
        chk("maxlen_width", 32'(nbusy), 32'd16);

        // trig high through reset release: no pulse
        rst_n   = 1'b0;
        mode    = 4'b1101;
        trig    = 2'b01;
        tick();
        rst_n = 1'b1;
        nbusy = 0;
        for (int i = 1; i <= LAT + 5; i++) begin
            tick();
            if (busy_a[0] || out_a[7:0] != 8'h0) nbusy++;
        end
        chk("no_spurious", 32'(nbusy), 32'd0);

        // reset mid-pulse clears outputs without a clock edge
        trig[0] = 1'b0;
        in[7:0] = 8'h77;
        len     = 4'd9;
        repeat (LAT + 2) tick();
        trig[0] = 1'b1;
        repeat (LAT + 1) tick();
        chk("pulse_before_rst", 32'(busy_a[0]), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",  32'(out_a[7:0]), 32'h0);
        chk("async_rst_busy", 32'(busy_a[0]),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
